// File: rtl/if_id_latch_if.sv
// Fetch/decode handshake bundle for the IF/ID latch.
// The master side drives the fetch and hazard signals. The slave side is the latch itself.
interface if_id_latch_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] if_instr;
  logic [WIDTH-1:0] if_pc2;
  logic             if_valid;
  logic             if_ready;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] id_instr;
  logic [WIDTH-1:0] id_pc2;
  logic [4:0]       id_opcode;
  logic [1:0]       id_mode;
  logic             id_valid;
  logic             halted;

  modport master (
    output if_instr, if_pc2, if_valid, stall, flush,
    input  if_ready, id_instr, id_pc2, id_opcode, id_mode, id_valid, halted
  );

  modport slave (
    input  if_instr, if_pc2, if_valid, stall, flush,
    output if_ready, id_instr, id_pc2, id_opcode, id_mode, id_valid, halted
  );
endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline register with a one-entry skid buffer, hazard stall, branch flush
// and HALT tracking. Once a HALT leaves decode, fetch stays stopped until reset.
module if_id_latch #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]       HALT_OPC  = 5'b00000
) (
  input logic          clk,
  input logic          rst_n,
  if_id_latch_if.slave bus
);
  typedef enum logic [1:0] {S_RUN, S_HALT_PEND, S_HALTED} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_id_instr, w_id_instr_next;
  logic [WIDTH-1:0] r_id_pc2, w_id_pc2_next;
  logic [WIDTH-1:0] r_skid_instr, w_skid_instr_next;
  logic [WIDTH-1:0] r_skid_pc2, w_skid_pc2_next;
  logic             r_id_valid, w_id_valid_next;
  logic             r_skid_full, w_skid_full_next;
  logic             r_halted, w_halted_next;
  logic             w_ready, w_xfer, w_load;

  // Ready comes from registered state only, so it never loops back through if_valid.
  assign w_ready = rst_n & ~r_skid_full & (r_state == S_RUN);
  assign w_xfer  = bus.if_valid & w_ready;

  always_comb begin
    w_state_next      = r_state;
    w_id_instr_next   = r_id_instr;
    w_id_pc2_next     = r_id_pc2;
    w_id_valid_next   = r_id_valid;
    w_skid_instr_next = r_skid_instr;
    w_skid_pc2_next   = r_skid_pc2;
    w_skid_full_next  = r_skid_full;
    w_halted_next     = r_halted;
    w_load            = 1'b0;

    if (r_state == S_HALTED) begin
      w_id_valid_next = 1'b0;
    end else if (bus.flush) begin
      w_id_valid_next  = 1'b0;
      w_id_instr_next  = NOP_INSTR;
      w_skid_full_next = 1'b0;
      w_state_next     = S_RUN;
    end else if (bus.stall) begin
      if (w_xfer && !r_skid_full) begin
        w_skid_instr_next = bus.if_instr;
        w_skid_pc2_next   = bus.if_pc2;
        w_skid_full_next  = 1'b1;
      end
    end else if (r_state == S_HALT_PEND) begin
      w_state_next    = S_HALTED;
      w_halted_next   = 1'b1;
      w_id_valid_next = 1'b0;
      w_id_instr_next = NOP_INSTR;
    end else begin
      if (r_skid_full) begin
        w_id_instr_next   = r_skid_instr;
        w_id_pc2_next     = r_skid_pc2;
        w_id_valid_next   = 1'b1;
        w_load            = 1'b1;
        w_skid_full_next  = w_xfer;
        w_skid_instr_next = bus.if_instr;
        w_skid_pc2_next   = bus.if_pc2;
      end else if (w_xfer) begin
        w_id_instr_next = bus.if_instr;
        w_id_pc2_next   = bus.if_pc2;
        w_id_valid_next = 1'b1;
        w_load          = 1'b1;
      end else begin
        w_id_valid_next = 1'b0;
        w_id_instr_next = NOP_INSTR;
      end
      // A HALT entering decode discards anything younger already sitting in the skid.
      if (w_load && (w_id_instr_next[WIDTH-1 -: 5] == HALT_OPC)) begin
        w_state_next     = S_HALT_PEND;
        w_skid_full_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_id_instr   <= NOP_INSTR;
      r_id_pc2     <= '0;
      r_id_valid   <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc2   <= '0;
      r_skid_full  <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_id_instr   <= w_id_instr_next;
      r_id_pc2     <= w_id_pc2_next;
      r_id_valid   <= w_id_valid_next;
      r_skid_instr <= w_skid_instr_next;
      r_skid_pc2   <= w_skid_pc2_next;
      r_skid_full  <= w_skid_full_next;
      r_halted     <= w_halted_next;
    end
  end

  assign bus.if_ready  = w_ready;
  assign bus.id_instr  = r_id_instr;
  assign bus.id_pc2    = r_id_pc2;
  assign bus.id_opcode = r_id_instr[WIDTH-1 -: 5];
  assign bus.id_mode   = r_id_instr[1:0];
  assign bus.id_valid  = r_id_valid;
  assign bus.halted    = r_halted;
endmodule
